fifo_rd_stream_adapter: RTL and testbench

//  Read-side stage that sits directly downstream of the single-port-RAM sync FIFO.

---
 rtl/fifo_rd_stream_adapter.sv | 85 ++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter: turns a registered-read sync FIFO (rd_en/dout/empty) into a
// first-word-fall-through valid/ready stream, using a 2-entry head/skid store.
module fifo_rd_stream_adapter #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fifo_empty,
   output logic          fifo_rd_en,
   input  logic [DW-1:0] fifo_dout,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic [1:0]    level
);

   localparam int unsigned DEPTH = 2;

   logic          r_out_vld;
   logic [DW-1:0] r_out_dat;
   logic          r_skd_vld;
   logic [DW-1:0] r_skd_dat;
   logic          r_pend;

   logic          w_pop;
   logic [1:0]    w_level;
   logic [2:0]    w_occ;
   logic          w_head_load;
   logic          w_skid_shift;

   // Stream handshake: a word transfers on a rising edge where m_valid && m_ready;
   // once m_valid is high, m_valid and m_data hold until that transfer happens.
   assign w_pop   = r_out_vld & m_ready;
   assign w_level = {1'b0, r_out_vld} + {1'b0, r_skd_vld};

   // Credit counts held words plus the read in flight, minus the word leaving now.
   assign w_occ      = {1'b0, w_level} + {2'b00, r_pend} - {2'b00, w_pop};
   assign fifo_rd_en = rst_n & ~fifo_empty & (w_occ < 3'(DEPTH));

   assign w_head_load  = ~r_out_vld | (w_pop & ~r_skd_vld);
   assign w_skid_shift = w_pop & r_skd_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= 1'b0;
      end else begin
         r_pend <= fifo_rd_en;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld <= 1'b0;
         r_out_dat <= '0;
         r_skd_vld <= 1'b0;
         r_skd_dat <= '0;
      end else if (w_head_load) begin
         r_out_vld <= r_pend;
         if (r_pend) begin
            r_out_dat <= fifo_dout;
         end
      end else if (w_skid_shift) begin
         r_out_vld <= 1'b1;
         r_out_dat <= r_skd_dat;
         r_skd_vld <= r_pend;
         if (r_pend) begin
            r_skd_dat <= fifo_dout;
         end
      end else if (r_pend) begin
         r_skd_vld <= 1'b1;
         r_skd_dat <= fifo_dout;
      end
   end

   assign m_valid = r_out_vld;
   assign m_data  = r_out_dat;
   assign level   = w_level;

   a_credit_bound : assert property (@(posedge clk) disable iff (!rst_n)
      ({1'b0, w_level} + {2'b00, r_pend}) <= 3'(DEPTH));

   a_skid_no_overwrite : assert property (@(posedge clk) disable iff (!rst_n)
      !(r_pend && r_skd_vld && !w_pop));

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench: behavioural sync FIFO (AW=4, DW=16) feeding fifo_rd_stream_adapter, with
// directed cases plus a randomized run checked against a count/queue reference model.
module tb_fifo_rd_stream_adapter;

  localparam int DW     = 16;
  localparam int AW     = 4;
  localparam int FDEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- upstream sync FIFO model (registered read) ----------------
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] f_mem [FDEPTH];
  logic [AW:0]   f_wp, f_rp;
  logic [DW-1:0] f_dout;
  logic          f_empty, f_full;
  logic          force_ne;
  logic          dut_empty;

  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    level;

  assign f_empty   = (f_wp == f_rp);
  assign f_full    = (f_wp[AW] != f_rp[AW]) && (f_wp[AW-1:0] == f_rp[AW-1:0]);
  assign dut_empty = force_ne ? 1'b0 : f_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_wp   <= '0;
      f_rp   <= '0;
      f_dout <= '0;
    end else begin
      if (wr_en && !f_full) begin
        f_mem[f_wp[AW-1:0]] <= wr_data;
        f_wp <= f_wp + 1'b1;
      end
      if (fifo_rd_en && !f_empty) begin
        f_dout <= f_mem[f_rp[AW-1:0]];
        f_rp   <= f_rp + 1'b1;
      end
    end
  end

  fifo_rd_stream_adapter #(.DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (dut_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (f_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .level      (level)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  int            rd_total, pop_total, recv_cnt, exp_level;
  bit            prev_rd, hold_pend, cur_pop;
  logic [DW-1:0] held_dat;

  // Reference: a read accepted in cycle n is held from cycle n+2 on, so the held
  // count equals all reads except the latest one, minus everything popped so far.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_total  = 0;
      pop_total = 0;
      prev_rd   = 1'b0;
      hold_pend = 1'b0;
    end else begin
      exp_level = rd_total - (prev_rd ? 1 : 0) - pop_total;
      check_eq("level", 32'(level), 32'(exp_level));
      check_eq("m_valid", 32'(m_valid), 32'(exp_level > 0));
      check_eq("credit", 32'((32'(level) + 32'(prev_rd)) <= 2), 32'd1);
      if (f_empty && !force_ne) check_eq("rd_when_empty", 32'(fifo_rd_en), 32'd0);
      if (hold_pend) begin
        check_eq("hold_valid", 32'(m_valid), 32'd1);
        check_eq("hold_data", 32'(m_data), 32'(held_dat));
      end
      cur_pop = m_valid && m_ready;
      if (cur_pop) begin
        recv_cnt++;
        if (exp_q.size() == 0) check_eq("pop_unexpected", 32'(exp_q.size()), 32'd1);
        else check_eq("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      hold_pend = m_valid && !m_ready;
      held_dat  = m_data;
      rd_total  += fifo_rd_en ? 1 : 0;
      pop_total += cur_pop ? 1 : 0;
      prev_rd   = fifo_rd_en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_words(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = first + DW'(i);
      if (!f_full) exp_q.push_back(wr_data);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      step();
      c++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed-case sampling ----------------
  logic [DW-1:0] beat_q[$];
  int            beat_cyc[$];
  int            first_rd, rd_cnt;
  logic          last_rd;

  task automatic sample_window(input int ncyc);
    beat_q.delete();
    beat_cyc.delete();
    first_rd = -1;
    rd_cnt   = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = c;
      end
      if (m_valid && m_ready) begin
        beat_q.push_back(m_data);
        beat_cyc.push_back(c);
      end
      last_rd = fifo_rd_en;
    end
  endtask

  int ready_pct;
  bit wr_done;

  initial begin
    wr_en    = 1'b0;
    wr_data  = '0;
    m_ready  = 1'b0;
    force_ne = 1'b1;
    rst_n    = 1'b0;
    recv_cnt = 0;

    // 1: reset held with a non-empty upstream flag
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    step();
    force_ne = 1'b0;
    rst_n    = 1'b1;
    step();

    // 2: stream of 5 words with m_ready held high
    m_ready = 1'b1;
    fork
      push_words(16'h0001, 5);
      sample_window(12);
    join
    check_eq("stream_beats", 32'(beat_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < beat_q.size()) begin
        check_eq("stream_data", 32'(beat_q[i]), 32'(i + 1));
        check_eq("stream_consec", 32'(beat_cyc[i]), 32'(beat_cyc[0] + i));
      end
    end
    // rd_en is taken at edge k, registered data appears after k, head loads at k+1.
    if (beat_q.size() > 0) check_eq("stream_latency", 32'(beat_cyc[0]), 32'(first_rd + 2));
    step();
    wait_drain("stream_drain", 20);

    // 3: backpressure with 4 preloaded words
    m_ready = 1'b0;
    fork
      push_words(16'h0001, 4);
      sample_window(12);
    join
    check_eq("bp_rd_pulses", 32'(rd_cnt), 32'd2);
    check_eq("bp_level", 32'(level), 32'd2);
    check_eq("bp_valid", 32'(m_valid), 32'd1);
    check_eq("bp_data", 32'(m_data), 32'h0001);
    step();
    m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_eq("bp_release_valid", 32'(m_valid), 32'd1);
      check_eq("bp_release_data", 32'(m_data), 32'(k));
    end
    step();
    wait_drain("bp_drain", 20);

    // 4: single last word
    repeat (3) step();
    fork
      push_words(16'h00AB, 1);
      sample_window(10);
    join
    check_eq("last_rd_pulses", 32'(rd_cnt), 32'd1);
    check_eq("last_beats", 32'(beat_q.size()), 32'd1);
    if (beat_q.size() > 0) check_eq("last_data", 32'(beat_q[0]), 32'h00AB);
    check_eq("last_rd_idle", 32'(last_rd), 32'd0);
    step();

    // 5: randomized traffic, 1000 words
    recv_cnt  = 0;
    wr_done   = 1'b0;
    ready_pct = 50;
    fork
      begin
        int n = 0;
        int guard = 0;
        while (n < 1000 && guard < 30000) begin
          if (!f_full && $urandom_range(0, 3) != 0) begin
            wr_en   = 1'b1;
            wr_data = DW'($urandom);
            exp_q.push_back(wr_data);
            n++;
          end else begin
            wr_en = 1'b0;
          end
          step();
          guard++;
        end
        wr_en   = 1'b0;
        wr_done = 1'b1;
      end
      begin
        int guard = 0;
        while ((!wr_done || exp_q.size() != 0) && guard < 40000) begin
          if (guard % 100 == 0) begin
            case ($urandom_range(0, 3))
              0: ready_pct = 10;
              1: ready_pct = 50;
              2: ready_pct = 90;
              default: ready_pct = 100;
            endcase
          end
          m_ready = ($urandom_range(0, 99) < ready_pct);
          step();
          guard++;
        end
      end
    join
    check_eq("rand_drained", 32'(exp_q.size()), 32'd0);
    check_eq("rand_recv", 32'(recv_cnt), 32'd1000);

    // 6: reset while the store is full and a read is being issued
    m_ready = 1'b0;
    push_words(16'h6001, 4);
    repeat (8) step();
    @(negedge clk);
    check_eq("mid_pre_level", 32'(level), 32'd2);
    step();
    m_ready = 1'b1;
    #1;
    check_eq("mid_pre_rd_en", 32'(fifo_rd_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(m_valid), 32'd0);
    check_eq("mid_rst_data", 32'(m_data), 32'd0);
    check_eq("mid_rst_level", 32'(level), 32'd0);
    check_eq("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    exp_q.delete();
    recv_cnt = 0;
    m_ready  = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    push_words(16'hC001, 3);
    wait_drain("mid_post_drain", 30);
    repeat (4) step();
    check_eq("mid_post_recv", 32'(recv_cnt), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    errors++;
    checks++;
    $display("FAIL watchdog: got=timeout expected=completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
